// File: rtl/config_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration chain loader.
package config_chain_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam int DEF_WORD_WIDTH   = 32;
  localparam int DEF_CHAIN_LENGTH = 216;
  localparam int DEF_CLEAR_CYCLES = 2;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/config_chain_loader_word_serializer.sv
// Latches one bitstream word and selects the bit to be shifted next, LSB first.
module config_chain_loader_word_serializer
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clock_i,
  input  logic                  nreset_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [WORD_WIDTH-1:0] data_i,
  output logic                  last_bit_o,
  output logic                  bit_nxt_o
);

  localparam int IW = cnt_w(WORD_WIDTH);

  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]         idx_q, idx_d;

  always_comb begin
    word_d = load_i ? data_i : word_q;
    idx_d  = idx_q;
    if (load_i)         idx_d = '0;
    else if (advance_i) idx_d = idx_q + IW'(1);
  end

  // Look-ahead bit: the top registers config_data from this so it lines up
  // with the cycle in which the bit is enabled into the chain.
  assign bit_nxt_o  = word_d[idx_d];
  assign last_bit_o = (idx_q == IW'(WORD_WIDTH - 1));

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Clears the tile configuration chain, then serialises CHAIN_LENGTH bitstream bits into it.
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic                  clock_i,
  input  logic                  nreset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WORD_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic                  config_data_o,
  output logic                  config_enable_o,
  output logic                  config_nreset_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int BCW = cnt_w(CHAIN_LENGTH + 1);
  localparam int CCW = cnt_w(CLEAR_CYCLES + 1);

  state_e         state_q, state_d;
  logic [BCW-1:0] bit_count_q, bit_count_d;
  logic [CCW-1:0] clr_count_q, clr_count_d;
  logic           error_q, error_d;
  logic           load, advance, last_bit, bit_nxt;
  logic           s_ready_q, data_q, enable_q, cfg_nreset_q, busy_q, done_q;

  config_chain_loader_word_serializer #(.WORD_WIDTH(WORD_WIDTH)) u_ser (
    .clock_i   (clock_i),
    .nreset_i  (nreset_i),
    .load_i    (load),
    .advance_i (advance),
    .data_i    (s_data_i),
    .last_bit_o(last_bit),
    .bit_nxt_o (bit_nxt)
  );

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    clr_count_d = clr_count_q;
    error_d     = error_q;
    load        = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) begin
        state_d     = ST_CLEAR;
        error_d     = 1'b0;
        bit_count_d = '0;
        clr_count_d = '0;
      end
      ST_CLEAR: if (abort_i) begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end else begin
        clr_count_d = clr_count_q + CCW'(1);
        if (clr_count_q == CCW'(CLEAR_CYCLES - 1)) state_d = ST_LOAD;
      end
      // s_ready is high exactly while in LOAD, so s_valid alone completes the handshake.
      ST_LOAD: if (abort_i) begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end else if (s_valid_i) begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (abort_i) begin
        state_d = ST_IDLE;
        error_d = 1'b1;
      end else begin
        advance     = 1'b1;
        bit_count_d = bit_count_q + BCW'(1);
        if (bit_count_d == BCW'(CHAIN_LENGTH)) state_d = ST_DONE;
        else if (last_bit)                     state_d = ST_LOAD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q      <= ST_IDLE;
      bit_count_q  <= '0;
      clr_count_q  <= '0;
      error_q      <= 1'b0;
      s_ready_q    <= 1'b0;
      data_q       <= 1'b0;
      enable_q     <= 1'b0;
      cfg_nreset_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_count_q  <= bit_count_d;
      clr_count_q  <= clr_count_d;
      error_q      <= error_d;
      s_ready_q    <= (state_d == ST_LOAD);
      data_q       <= (state_d == ST_SHIFT) && bit_nxt;
      enable_q     <= (state_d == ST_SHIFT);
      cfg_nreset_q <= (state_d != ST_CLEAR);
      busy_q       <= (state_d == ST_CLEAR) || (state_d == ST_LOAD) || (state_d == ST_SHIFT);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign s_ready_o       = s_ready_q;
  assign config_data_o   = data_q;
  assign config_enable_o = enable_q;
  assign config_nreset_o = cfg_nreset_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboarded random bench: a chain model is compared against bitstream-derived expectations.
module tb_config_chain_loader;

  localparam int WW = 32, CL = 216, CC = 2, NW = (CL + WW - 1) / WW;
  localparam int LAT = CC + NW * (1 + WW) - (NW * WW - CL) + 1;
  localparam int WW2 = 8, CL2 = 24, NW2 = (CL2 + WW2 - 1) / WW2;
  localparam int LAT2 = CC + NW2 * (1 + WW2) - (NW2 * WW2 - CL2) + 1;

  logic clk = 1'b0, nreset = 1'b0;
  logic start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [WW-1:0] s_data = '0;
  logic s_ready, cfg_data, cfg_en, cfg_nrst, busy, done, error;
  logic start2 = 1'b0, abort2 = 1'b0, s_valid2 = 1'b0;
  logic [WW2-1:0] s_data2 = '0;
  logic s_ready2, cfg_data2, cfg_en2, cfg_nrst2, busy2, done2, error2;

  always #5 clk = ~clk;

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .CLEAR_CYCLES(CC)) u_dut (
    .clock_i(clk), .nreset_i(nreset), .start_i(start), .abort_i(abort),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .config_data_o(cfg_data), .config_enable_o(cfg_en), .config_nreset_o(cfg_nrst),
    .busy_o(busy), .done_o(done), .error_o(error));

  config_chain_loader #(.WORD_WIDTH(WW2), .CHAIN_LENGTH(CL2), .CLEAR_CYCLES(CC)) u_dut2 (
    .clock_i(clk), .nreset_i(nreset), .start_i(start2), .abort_i(abort2),
    .s_data_i(s_data2), .s_valid_i(s_valid2), .s_ready_o(s_ready2),
    .config_data_o(cfg_data2), .config_enable_o(cfg_en2), .config_nreset_o(cfg_nrst2),
    .busy_o(busy2), .done_o(done2), .error_o(error2));

  typedef struct {
    bit            aborted;
    logic [CL-1:0] chain;
    int            words;
    int            hs_base;
    int            done_cyc;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t m1, m2;
  int errors = 0, checks = 0;
  int cyc = 0, hs1 = 0, hs2 = 0, en_bad = 0;
  logic err_prev = 1'b0;
  logic [CL-1:0]  chain1;
  logic [CL2-1:0] chain2;

  task automatic chk(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid && s_ready)   hs1 <= hs1 + 1;
    if (s_valid2 && s_ready2) hs2 <= hs2 + 1;
  end

  // Tile chains: first bit in ends up at the highest index after CHAIN_LENGTH shifts.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      chain1 <= '0;
      chain2 <= '0;
    end else begin
      if (!cfg_nrst)   chain1 <= '0;
      else if (cfg_en) chain1 <= {chain1[CL-2:0], cfg_data};
      if (!cfg_nrst2)   chain2 <= '0;
      else if (cfg_en2) chain2 <= {chain2[CL2-2:0], cfg_data2};
    end
  end

  always @(negedge clk) begin
    if (cfg_en && (!busy || s_ready)) en_bad <= en_bad + 1;
    err_prev <= error;
    if (done) begin
      if (q1.size() == 0) fail_now("unexpected_done");
      else begin
        m1 = q1.pop_front();
        if (m1.aborted) fail_now("done_after_abort");
        chk("chain", chain1, m1.chain);
        chk("handshakes", CL'(hs1 - m1.hs_base), CL'(m1.words));
        chk("error_at_done", CL'(error), '0);
        if (m1.done_cyc > 0) chk("latency_cycle", CL'(cyc), CL'(m1.done_cyc));
      end
    end
    if (error && !err_prev) begin
      if (q1.size() == 0) fail_now("unexpected_error");
      else begin
        m1 = q1.pop_front();
        if (!m1.aborted) fail_now("error_without_abort");
        chk("abort_busy", CL'(busy), '0);
        chk("abort_enable", CL'(cfg_en), '0);
      end
    end
    if (done2) begin
      if (q2.size() == 0) fail_now("unexpected_done2");
      else begin
        m2 = q2.pop_front();
        chk("chain2", CL'(chain2), CL'(m2.chain[CL2-1:0]));
        chk("handshakes2", CL'(hs2 - m2.hs_base), CL'(m2.words));
        chk("latency2", CL'(cyc), CL'(m2.done_cyc));
      end
    end
  end

  task automatic run_load(input int gap, input int abort_after, input bit poke, input bit rst_mid);
    logic [WW-1:0] w[NW];
    logic [CL-1:0] ex;
    exp_t e;
    int base, st, n_en, h;
    bit fin;
    for (int i = 0; i < NW; i++) w[i] = $urandom;
    for (int k = 0; k < CL; k++) ex[CL-1-k] = w[k/WW][k%WW];
    @(negedge clk);
    base = hs1;
    st = cyc;
    start = 1'b1;
    if (!rst_mid) begin
      e.aborted  = (abort_after >= 0);
      e.chain    = ex;
      e.words    = NW;
      e.hs_base  = base;
      e.done_cyc = (gap == 0 && abort_after < 0) ? st + LAT : 0;
      q1.push_back(e);
    end
    fin = 1'b0;
    n_en = 0;
    for (int t = 0; t < 4000 && !fin; t++) begin
      @(negedge clk);
      start = poke && busy && ($urandom_range(3) == 0);
      abort = 1'b0;
      h = hs1 - base;
      s_valid = (h < NW) && ($urandom_range(99) >= gap);
      s_data  = (s_valid && h < NW) ? w[h] : WW'($urandom);
      if (cfg_en) n_en++;
      if (done) fin = 1'b1;
      else if (abort_after >= 0 && h == abort_after && n_en >= (abort_after - 1) * WW + 10) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_idle_busy", CL'(busy), '0);
        chk("abort_error_set", CL'(error), CL'(1));
        repeat (2 * LAT) @(negedge clk);
        chk("abort_no_restart", CL'(busy), '0);
        fin = 1'b1;
      end else if (rst_mid && n_en == 50) begin
        #2 nreset = 1'b0;
        #1;
        chk("rst_outputs", CL'({s_ready, cfg_data, cfg_en, cfg_nrst, busy, done, error}), '0);
        @(negedge clk);
        nreset = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_release_nreset", CL'(cfg_nrst), CL'(1));
        chk("rst_release_busy", CL'(busy), '0);
        fin = 1'b1;
      end
    end
    if (!fin) fail_now("load_timeout");
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [WW2-1:0] w2[NW2];
    logic [CL-1:0]  ex2;
    exp_t e2;
    int base2, h2;
    bit fin2;
    #1;
    chk("reset_outputs", CL'({s_ready, cfg_data, cfg_en, cfg_nrst, busy, done, error}), '0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_nreset_high", CL'(cfg_nrst), CL'(1));
    chk("idle_not_busy", CL'(busy), '0);

    run_load(0, -1, 1'b0, 1'b0);
    run_load(50, -1, 1'b0, 1'b0);
    run_load(50, -1, 1'b0, 1'b0);
    run_load(0, 4, 1'b0, 1'b0);
    run_load(0, -1, 1'b0, 1'b0);
    run_load(30, -1, 1'b1, 1'b0);
    run_load(0, -1, 1'b0, 1'b1);
    run_load(0, -1, 1'b0, 1'b0);

    for (int i = 0; i < NW2; i++) w2[i] = WW2'($urandom);
    ex2 = '0;
    for (int k = 0; k < CL2; k++) ex2[CL2-1-k] = w2[k/WW2][k%WW2];
    @(negedge clk);
    base2 = hs2;
    e2.aborted = 1'b0;
    e2.chain = ex2;
    e2.words = NW2;
    e2.hs_base = base2;
    e2.done_cyc = cyc + LAT2;
    q2.push_back(e2);
    start2 = 1'b1;
    fin2 = 1'b0;
    for (int t = 0; t < 500 && !fin2; t++) begin
      @(negedge clk);
      start2 = 1'b0;
      h2 = hs2 - base2;
      s_valid2 = (h2 < NW2);
      s_data2 = (h2 < NW2) ? w2[h2] : '0;
      if (done2) fin2 = 1'b1;
    end
    if (!fin2) fail_now("load2_timeout");
    s_valid2 = 1'b0;
    repeat (4) @(negedge clk);

    chk("enable_outside_shift", CL'(en_bad), '0);
    chk("pending_expect", CL'(q1.size() + q2.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
